kalman_step_sequencer: RTL and testbench

KALMAN_STEP_SEQUENCER -- requirements
Module: kalman_step_sequencer

---
 rtl/kalman_step_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_kalman_step_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kalman_step_sequencer.sv
// Kalman step sequencer: averages plant output samples over a 2^LOG2_AVG
// window, then drives one prediction/update round of the state-equation stage
// with held U/Y values, tracking completed steps and error conditions.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a pending averaged window
// S_PRED   | U/Y loaded, Start_Prediction asserted for one enabled cycle
// S_WAIT_P | waiting for ready_Prediction, wait counter running
// S_UPD    | Start_Update asserted for one enabled cycle
// S_WAIT_U | waiting for ready_Update, wait counter running
// S_DONE   | step_done asserted, step_count advances on exit
// S_ERR    | ready timeout seen; absorbing until reset
module kalman_step_sequencer #(
   parameter int WIDTH    = 16,
   parameter int noo      = 2,
   parameter int noi      = 2,
   parameter int LOG2_AVG = 2,
   parameter int TIMEOUT  = 1023
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clk_en,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] Y_in [0:noo-1],
   input  logic [WIDTH-1:0] U_in [0:noi-1],
   input  logic             ready_Prediction,
   input  logic             ready_Update,
   output logic             Start_Prediction,
   output logic             Start_Update,
   output logic [WIDTH-1:0] U [0:noi-1],
   output logic [WIDTH-1:0] Y [0:noo-1],
   output logic             busy,
   output logic             step_done,
   output logic             overrun,
   output logic             timeout_err,
   output logic [15:0]      step_count
);

   localparam int AW = WIDTH + LOG2_AVG;
   // A zero-width window counter is not legal, so keep at least one bit.
   localparam int CW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
   localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] WIN_LAST  = CW'((1 << LOG2_AVG) - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRED,
      S_WAIT_P,
      S_UPD,
      S_WAIT_U,
      S_DONE,
      S_ERR
   } state_t;

   state_t state_q, state_d;

   logic signed [AW-1:0] lane     [noo];
   logic signed [AW-1:0] lane_sum [noo];
   logic [CW-1:0]        win_cnt;
   logic                 win_done;
   logic [WIDTH-1:0]     y_pend [noo];
   logic [WIDTH-1:0]     u_pend [noi];
   logic                 pend_valid;

   logic [WW-1:0]        wait_cnt;
   logic                 take;
   logic                 wait_clr;
   logic                 wait_inc;
   logic                 wait_expired;
   logic                 step_inc;

   // Lane sums including the current sample, sign-extended to the lane width.
   always_comb begin
      win_done = sample_valid && (win_cnt == WIN_LAST);
      for (int i = 0; i < noo; i++) begin
         lane_sum[i] = lane[i] + AW'(signed'(Y_in[i]));
      end
   end

   // Window accumulator and pending buffer; independent of the FSM state.
   always_ff @(posedge clk) begin
      if (reset) begin
         win_cnt    <= '0;
         pend_valid <= 1'b0;
         overrun    <= 1'b0;
         for (int i = 0; i < noo; i++) begin
            lane[i]   <= '0;
            y_pend[i] <= '0;
         end
         for (int j = 0; j < noi; j++) begin
            u_pend[j] <= '0;
         end
      end else if (clk_en) begin
         if (sample_valid) begin
            if (win_done) begin
               win_cnt <= '0;
               for (int i = 0; i < noo; i++) begin
                  lane[i]   <= '0;
                  y_pend[i] <= WIDTH'(lane_sum[i] >>> LOG2_AVG);
               end
               for (int j = 0; j < noi; j++) begin
                  u_pend[j] <= U_in[j];
               end
            end else begin
               win_cnt <= win_cnt + CW'(1);
               for (int i = 0; i < noo; i++) begin
                  lane[i] <= lane_sum[i];
               end
            end
         end
         // A window landing on the same edge the FSM drains the buffer is
         // simply the next pending entry, not an overrun.
         if (win_done) begin
            pend_valid <= 1'b1;
            if (pend_valid && !take) begin
               overrun <= 1'b1;
            end
         end else if (take) begin
            pend_valid <= 1'b0;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else if (clk_en) begin
         state_q <= state_d;
      end
   end

   // Next-state decode and Moore outputs; pulses last one enabled cycle
   // because they follow the registered state.
   always_comb begin
      state_d          = state_q;
      take             = 1'b0;
      wait_clr         = 1'b0;
      wait_inc         = 1'b0;
      wait_expired     = 1'b0;
      step_inc         = 1'b0;
      Start_Prediction = 1'b0;
      Start_Update     = 1'b0;
      step_done        = 1'b0;
      busy             = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pend_valid) begin
               take    = 1'b1;
               state_d = S_PRED;
            end
         end
         S_PRED: begin
            busy             = 1'b1;
            Start_Prediction = 1'b1;
            wait_clr         = 1'b1;
            state_d          = S_WAIT_P;
         end
         S_WAIT_P: begin
            busy = 1'b1;
            if (ready_Prediction) begin
               state_d = S_UPD;
            end else if (wait_cnt == WAIT_LAST) begin
               wait_expired = 1'b1;
               state_d      = S_ERR;
            end else begin
               wait_inc = 1'b1;
            end
         end
         S_UPD: begin
            busy         = 1'b1;
            Start_Update = 1'b1;
            wait_clr     = 1'b1;
            state_d      = S_WAIT_U;
         end
         S_WAIT_U: begin
            busy = 1'b1;
            if (ready_Update) begin
               state_d = S_DONE;
            end else if (wait_cnt == WAIT_LAST) begin
               wait_expired = 1'b1;
               state_d      = S_ERR;
            end else begin
               wait_inc = 1'b1;
            end
         end
         S_DONE: begin
            busy      = 1'b1;
            step_done = 1'b1;
            step_inc  = 1'b1;
            state_d   = S_IDLE;
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Ready wait counter, timeout flag and completed-step counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
         step_count  <= '0;
      end else if (clk_en) begin
         if (wait_clr) begin
            wait_cnt <= '0;
         end else if (wait_inc) begin
            wait_cnt <= wait_cnt + WW'(1);
         end
         if (wait_expired) begin
            timeout_err <= 1'b1;
         end
         if (step_inc) begin
            step_count <= step_count + 16'd1;
         end
      end
   end

   // Held U/Y for the state-equation stage; only reloaded when a step starts.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < noo; i++) begin
            Y[i] <= '0;
         end
         for (int j = 0; j < noi; j++) begin
            U[j] <= '0;
         end
      end else if (clk_en && take) begin
         for (int i = 0; i < noo; i++) begin
            Y[i] <= y_pend[i];
         end
         for (int j = 0; j < noi; j++) begin
            U[j] <= u_pend[j];
         end
      end
   end

endmodule

// File: tb/tb_kalman_step_sequencer.sv
// Directed bench for kalman_step_sequencer. Expected step results are queued
// when windows are fed; a monitor pops them on each Start_Prediction.
module tb_kalman_step_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clk_en = 1'b1;
   logic        toggle_mode = 1'b0;
   logic        sample_valid = 1'b0;
   logic [15:0] Y_in [0:1];
   logic [15:0] U_in [0:1];
   logic        ready_Prediction = 1'b0;
   logic        ready_Update = 1'b0;
   logic        Start_Prediction, Start_Update;
   logic [15:0] U [0:1];
   logic [15:0] Y [0:1];
   logic        busy, step_done, overrun, timeout_err;
   logic [15:0] step_count;

   typedef struct {
      logic [15:0] y0, y1, u0, u1, cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   logic have_cur = 1'b0;
   logic en_edge = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   kalman_step_sequencer #(
      .WIDTH(16), .noo(2), .noi(2), .LOG2_AVG(2), .TIMEOUT(1023)
   ) dut (
      .clk(clk), .reset(reset), .clk_en(clk_en), .sample_valid(sample_valid),
      .Y_in(Y_in), .U_in(U_in),
      .ready_Prediction(ready_Prediction), .ready_Update(ready_Update),
      .Start_Prediction(Start_Prediction), .Start_Update(Start_Update),
      .U(U), .Y(Y), .busy(busy), .step_done(step_done),
      .overrun(overrun), .timeout_err(timeout_err), .step_count(step_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) clk_en = toggle_mode ? ~clk_en : 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: one event per enabled edge, so held pulses are not double-counted.
   always @(posedge clk) en_edge = clk_en;

   always @(negedge clk) begin
      if (en_edge) begin
         if (Start_Prediction) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_start_p: got pulse with Y0=%0h expected none", Y[0]);
            end else begin
               cur = exp_q.pop_front();
               have_cur = 1'b1;
               chk("pred_y0", Y[0], cur.y0);
               chk("pred_y1", Y[1], cur.y1);
               chk("pred_u0", U[0], cur.u0);
               chk("pred_u1", U[1], cur.u1);
            end
         end
         if (Start_Update) begin
            if (!have_cur) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_start_u: got pulse expected none");
            end else begin
               chk("upd_y0", Y[0], cur.y0);
               chk("upd_u1", U[1], cur.u1);
            end
         end
         if (step_done) begin
            if (!have_cur) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_step_done: got pulse expected none");
            end else begin
               chk("done_count", step_count, cur.cnt);
               chk("done_y1", Y[1], cur.y1);
               chk("done_u0", U[0], cur.u0);
               have_cur = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      do @(posedge clk); while (clk_en !== 1'b1);
      @(negedge clk);
   endtask

   function automatic logic out_sel(input int sel);
      case (sel)
         0: return Start_Prediction;
         1: return Start_Update;
         2: return step_done;
         default: return timeout_err;
      endcase
   endfunction

   task automatic wait_out(input int sel, input int budget, input string name);
      int n = 0;
      while (!out_sel(sel) && n < budget) begin
         tick();
         n++;
      end
      chk(name, {31'd0, out_sel(sel)}, 32'd1);
   endtask

   task automatic push_exp(input logic [15:0] y0, y1, u0, u1, cnt);
      exp_t e;
      e.y0 = y0; e.y1 = y1; e.u0 = u0; e.u1 = u1; e.cnt = cnt;
      exp_q.push_back(e);
   endtask

   task automatic feed1(input int y0, input int y1, input logic [15:0] u0, input logic [15:0] u1);
      sample_valid = 1'b1;
      Y_in[0] = 16'(y0);
      Y_in[1] = 16'(y1);
      U_in[0] = u0;
      U_in[1] = u1;
      tick();
      sample_valid = 1'b0;
   endtask

   task automatic feed_win(input int y0 [4], input int y1 [4], input logic [15:0] u0,
                           input logic [15:0] u1, input int n);
      for (int i = 0; i < n; i++) feed1(y0[i], y1[i], u0, u1);
   endtask

   task automatic finish_step();
      ready_Prediction = 1'b1;
      repeat (3) tick();
      ready_Prediction = 1'b0;
      ready_Update = 1'b1;
      wait_out(2, 20, "wait_step_done");
      ready_Update = 1'b0;
      tick();
   endtask

   task automatic run_step();
      wait_out(0, 20, "wait_start_p");
      finish_step();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "global timeout");
   end

   initial begin
      Y_in[0] = '0; Y_in[1] = '0; U_in[0] = '0; U_in[1] = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_start_p", Start_Prediction, 0);
      chk("rst_start_u", Start_Update, 0);
      chk("rst_step_done", step_done, 0);
      chk("rst_count", step_count, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_y0", Y[0], 0);
      chk("rst_u1", U[1], 0);
      reset = 1'b0;
      tick();

      // Basic averaging and one full step: 4,8,12,16 -> 10; -1,-2,-2,-2 -> -2
      push_exp(16'd10, 16'hFFFE, 16'h1234, 16'hABCD, 16'd0);
      feed_win('{4, 8, 12, 16}, '{-1, -2, -2, -2}, 16'h1234, 16'hABCD, 4);
      run_step();
      chk("t1_count", step_count, 1);
      chk("t1_y0_held", Y[0], 10);
      chk("t1_busy", busy, 0);

      // Window completing on the same edge IDLE drains pending: no overrun
      push_exp(16'd20, 16'd0, 16'd5, 16'd6, 16'd1);
      feed_win('{20, 20, 20, 20}, '{0, 0, 0, 0}, 16'd5, 16'd6, 4);
      wait_out(0, 20, "t3_start_p");
      ready_Prediction = 1'b1;
      repeat (3) tick();
      ready_Prediction = 1'b0;
      push_exp(16'd40, 16'hFFD8, 16'd7, 16'd8, 16'd2);
      feed_win('{40, 40, 40, 40}, '{-40, -40, -40, -40}, 16'd7, 16'd8, 4);
      feed_win('{-4, -4, -4, -4}, '{9, 9, 9, 9}, 16'd9, 16'd10, 3);
      ready_Update = 1'b1;
      tick();
      ready_Update = 1'b0;
      tick();
      push_exp(16'hFFFC, 16'd9, 16'd9, 16'd10, 16'd3);
      feed1(-4, 9, 16'd9, 16'd10);
      chk("t3_no_overrun", overrun, 0);
      finish_step();
      run_step();
      chk("t3_count", step_count, 4);
      chk("t3_overrun_still0", overrun, 0);

      // Stall in WAIT_P while two more windows complete: overrun, last wins
      push_exp(16'd100, 16'hFFF8, 16'd1, 16'd2, 16'd4);
      feed_win('{100, 100, 100, 100}, '{-8, -8, -8, -8}, 16'd1, 16'd2, 4);
      wait_out(0, 20, "t2_start_p");
      feed_win('{1, 2, 3, 4}, '{0, 0, 0, 3}, 16'h11, 16'h22, 4);
      chk("t2_overrun_after_one", overrun, 0);
      feed_win('{7, 7, 7, 7}, '{-3, -3, -3, -4}, 16'h33, 16'h44, 4);
      chk("t2_overrun", overrun, 1);
      chk("t2_y0_stable", Y[0], 100);
      push_exp(16'd7, 16'hFFFC, 16'h33, 16'h44, 16'd5);
      finish_step();
      run_step();
      chk("t2_count", step_count, 6);

      // Same step as the first one with clk_en toggling every cycle
      toggle_mode = 1'b1;
      push_exp(16'd10, 16'hFFFE, 16'h1234, 16'hABCD, 16'd6);
      feed_win('{4, 8, 12, 16}, '{-1, -2, -2, -2}, 16'h1234, 16'hABCD, 4);
      run_step();
      chk("t4_count", step_count, 7);
      toggle_mode = 1'b0;
      tick();
      tick();

      // Reset in WAIT_U with a partial window outstanding
      push_exp(16'd8, 16'd8, 16'd1, 16'd1, 16'd7);
      feed_win('{8, 8, 8, 8}, '{8, 8, 8, 8}, 16'd1, 16'd1, 4);
      wait_out(0, 20, "t5_start_p");
      ready_Prediction = 1'b1;
      repeat (3) tick();
      ready_Prediction = 1'b0;
      feed_win('{100, 100, 0, 0}, '{100, 100, 0, 0}, 16'd9, 16'd9, 2);
      chk("t5_busy_before", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("t5_busy", busy, 0);
      chk("t5_start_p", Start_Prediction, 0);
      chk("t5_start_u", Start_Update, 0);
      chk("t5_step_done", step_done, 0);
      chk("t5_count", step_count, 0);
      chk("t5_overrun", overrun, 0);
      chk("t5_y0", Y[0], 0);
      chk("t5_y1", Y[1], 0);
      chk("t5_u0", U[0], 0);
      reset = 1'b0;
      tick();
      push_exp(16'd1, 16'hFFFE, 16'd3, 16'd4, 16'd0);
      feed_win('{1, 1, 1, 1}, '{-2, -2, -2, -2}, 16'd3, 16'd4, 4);
      run_step();
      chk("t5_count_after", step_count, 1);

      // Timeout in WAIT_U: 2,2,2,3 -> 2; -5,-6,-7,-8 -> -7
      push_exp(16'd2, 16'hFFF9, 16'hFFFF, 16'h8000, 16'd1);
      feed_win('{2, 2, 2, 3}, '{-5, -6, -7, -8}, 16'hFFFF, 16'h8000, 4);
      wait_out(0, 20, "t6_start_p");
      ready_Prediction = 1'b1;
      repeat (3) tick();
      ready_Prediction = 1'b0;
      repeat (1022) tick();
      chk("t6_timeout_early", timeout_err, 0);
      chk("t6_busy_waiting", busy, 1);
      tick();
      chk("t6_timeout", timeout_err, 1);
      chk("t6_busy_err", busy, 0);
      feed_win('{5, 5, 5, 5}, '{5, 5, 5, 5}, 16'd0, 16'd0, 4);
      chk("t6_no_overrun_one", overrun, 0);
      feed_win('{6, 6, 6, 6}, '{6, 6, 6, 6}, 16'd0, 16'd0, 4);
      chk("t6_overrun_in_err", overrun, 1);
      repeat (10) tick();
      chk("t6_y0_held", Y[0], 2);
      chk("t6_count", step_count, 1);
      chk("t6_queue_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
